uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit channel among NB_REQ byte-stream requesters. Grants the channel per message (a sequence of bytes ending in a byte flagged last), forwards the owner's bytes into the UART write port paced by the UART empty flag, then rotates priority. Sits between on-chip producers and the `uart` top-level `i_we`/`i_data`/`o_mty` port.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings,
// default byte width and the round-robin pointer wrap helper.
package uart_pkg;

    localparam int UART_WIDTH_DATA = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Rotated priority search; the first hit locks out later candidates
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
                gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
                idx_o = IW'((int'(ptr_i) + i) % N);
                any_o = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-message arbiter feeding a single UART write port.
// Define UART_ARB_HDR_EN to prefix every grant with one header byte HDR_BASE|owner.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int                    NB_REQ     = 4,
    parameter int                    WIDTH_DATA = UART_WIDTH_DATA,
    parameter int                    MAX_BURST  = 16,
    parameter logic [WIDTH_DATA-1:0] HDR_BASE   = 8'hF0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NB_REQ-1:0]            i_req,
    input  logic [NB_REQ*WIDTH_DATA-1:0] i_data,
    input  logic [NB_REQ-1:0]            i_last,
    output logic [NB_REQ-1:0]            o_ack,
    output logic [NB_REQ-1:0]            o_gnt,
    output logic                         o_busy,
    output logic                         o_we,
    output logic [WIDTH_DATA-1:0]        o_data,
    input  logic                         i_mty
);

    localparam int             IW       = $clog2(NB_REQ);
    localparam int             CW       = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d, owner_q, owner_d, pick_idx_s;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NB_REQ-1:0]       gnt_q, gnt_d, pick_gnt_s, ack_s;
    logic                    busy_q, pick_any_s, we_s, release_s;
    logic                    own_req_s, own_last_s;
    logic [WIDTH_DATA-1:0]   data_s, own_byte_s;

    rr_pick #(.N(NB_REQ), .IW(IW)) u_pick (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt_s),
        .idx_o (pick_idx_s),
        .any_o (pick_any_s)
    );

    assign own_req_s  = i_req[owner_q];
    assign own_last_s = i_last[owner_q];
    assign own_byte_s = i_data[int'(owner_q)*WIDTH_DATA +: WIDTH_DATA];

`ifndef UART_ARB_HDR_EN
    logic unused_hdr_s;
    assign unused_hdr_s = ^HDR_BASE;
`endif

    // Next-state, grant bookkeeping and the combinational UART write port
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        we_s      = 1'b0;
        data_s    = '0;
        ack_s     = '0;
        release_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    owner_d = pick_idx_s;
                    gnt_d   = pick_gnt_s;
                    cnt_d   = '0;
`ifdef UART_ARB_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_DATA;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef UART_ARB_HDR_EN
            ST_HDR: begin
                we_s   = 1'b1;
                data_s = HDR_BASE | WIDTH_DATA'(owner_q);
                if (i_mty) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
`endif
            ST_DATA: begin
                we_s   = own_req_s;
                data_s = own_byte_s;
                if (!own_req_s) begin
                    release_s = 1'b1;
                end else if (i_mty) begin
                    ack_s[owner_q] = 1'b1;
                    cnt_d          = cnt_q + CW'(1);
                    // A last byte landing on the burst limit still releases only once
                    release_s      = own_last_s || (cnt_q == CNT_LAST);
                end else begin
                    release_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (release_s) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            ptr_d   = IW'(rr_next(int'(owner_q), NB_REQ));
        end else begin
            ptr_d = ptr_d;
        end
    end

    // State, pointer, owner, burst count and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign o_ack  = ack_s;
    assign o_we   = we_s;
    assign o_data = data_s;
    assign o_gnt  = gnt_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: message-level reference model checked
// every cycle, directed literal scenarios, then randomized requesters and UART pacing.
module tb_uart_tx_arbiter;

    localparam int          NB  = 4;
    localparam int          W   = 8;
    localparam int          MB  = 16;
    localparam logic [7:0]  HDR = 8'hF0;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [NB-1:0]   i_req = '0;
    logic [NB*W-1:0] i_data = '0;
    logic [NB-1:0]   i_last = '0;
    logic            i_mty = 1'b1;
    logic [NB-1:0]   o_ack, o_gnt;
    logic            o_busy, o_we;
    logic [W-1:0]    o_data;

    uart_tx_arbiter #(.NB_REQ(NB), .WIDTH_DATA(W), .MAX_BURST(MB), .HDR_BASE(HDR)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data), .i_last(i_last),
        .o_ack(o_ack), .o_gnt(o_gnt), .o_busy(o_busy), .o_we(o_we), .o_data(o_data),
        .i_mty(i_mty)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: owner index (-1 when idle), rotating start point, bytes sent.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    bit            m_hdr   = 1'b0;
    int            burst_hits = 0;
    logic [NB-1:0] exp_gnt, exp_ack;
    logic          exp_we;
    logic [W-1:0]  exp_data;
    bit            found;

    always @(negedge i_clk) begin
        exp_gnt = '0; exp_ack = '0; exp_we = 1'b0; exp_data = '0;
        if (m_owner >= 0) begin
            exp_gnt[m_owner] = 1'b1;
            if (m_hdr) begin
                exp_we   = 1'b1;
                exp_data = HDR | 8'(m_owner);
            end else begin
                exp_we   = i_req[m_owner];
                exp_data = i_data[m_owner*W +: W];
                if (exp_we && i_mty) exp_ack[m_owner] = 1'b1;
            end
        end
        if (chk_en) begin
            chk("gnt", 32'(o_gnt), 32'(exp_gnt));
            chk("busy", 32'(o_busy), 32'(m_owner >= 0));
            chk("we", 32'(o_we), 32'(exp_we));
            chk("ack", 32'(o_ack), 32'(exp_ack));
            if (exp_we) chk("data", 32'(o_data), 32'(exp_data));
        end
        if (i_rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_hdr = 1'b0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int i = 0; i < NB; i++) begin
                if (!found && i_req[(m_ptr + i) % NB]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + i) % NB;
                    m_cnt   = 0;
`ifdef UART_ARB_HDR_EN
                    m_hdr   = 1'b1;
`endif
                end
            end
        end else if (m_hdr) begin
            if (i_mty) m_hdr = 1'b0;
        end else if (!i_req[m_owner]) begin
            m_ptr = (m_owner + 1) % NB; m_owner = -1;
        end else if (i_mty) begin
            m_cnt++;
            if (i_last[m_owner] || m_cnt == MB) begin
                if (!i_last[m_owner]) burst_hits++;
                m_ptr = (m_owner + 1) % NB; m_owner = -1;
            end
        end
    end

    // Randomized requesters: each holds a message and presents bytes until acked.
    logic [7:0]    msg [NB][20];
    int            len [NB];
    int            pos [NB];
    bit            pres [NB];
    logic [NB-1:0] ack_v;

    task automatic drive_random(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge i_clk); ack_v = o_ack;
            @(posedge i_clk); #1;
            for (int k = 0; k < NB; k++) begin
                if (pres[k] && ack_v[k]) begin
                    pos[k]++;
                    if (pos[k] >= len[k]) pres[k] = 1'b0;
                end else if (pres[k] && $urandom_range(0, 59) == 0) begin
                    pres[k] = 1'b0;
                end else if (!pres[k] && $urandom_range(0, 2) == 0) begin
                    if (pos[k] >= len[k]) begin
                        len[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 20))
                                                             : int'($urandom_range(1, 6));
                        pos[k] = 0;
                        for (int j = 0; j < 20; j++) msg[k][j] = 8'($urandom);
                    end
                    pres[k] = 1'b1;
                end
                i_req[k]        = pres[k];
                i_data[k*W +: W] = pres[k] ? msg[k][pos[k]] : 8'($urandom);
                i_last[k]       = pres[k] ? (pos[k] == len[k] - 1) : 1'($urandom);
            end
            i_rst = (c == ncyc / 2);
            i_mty = ($urandom_range(0, 3) != 0);
        end
    endtask

    int n1;
    bit got2;

    initial begin
        for (int k = 0; k < NB; k++) begin len[k] = 0; pos[k] = 0; pres[k] = 1'b0; end
        @(posedge i_clk); #1; chk_en = 1'b1;
        @(negedge i_clk);
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_we", 32'(o_we), 32'h0);
        chk("rst_ack", 32'(o_ack), 32'h0);
        chk("rst_data", 32'(o_data), 32'h0);
        @(posedge i_clk); #1; i_rst = 1'b0;

        // Requester 2 sends 11, 22(last)
        @(posedge i_clk); #1;
        i_req = 4'b0100; i_data = 32'h0011_0000; i_last = 4'b0000; i_mty = 1'b1;
        @(negedge i_clk); chk("d1_gnt_idle", 32'(o_gnt), 32'h0);
        @(posedge i_clk); #1;
`ifdef UART_ARB_HDR_EN
        @(negedge i_clk);
        chk("d1_hdr_data", 32'(o_data), 32'hF2);
        chk("d1_hdr_ack", 32'(o_ack), 32'h0);
        @(posedge i_clk); #1;
`endif
        @(negedge i_clk);
        chk("d1_gnt", 32'(o_gnt), 32'h4);
        chk("d1_byte0", 32'(o_data), 32'h11);
        chk("d1_ack0", 32'(o_ack), 32'h4);
        @(posedge i_clk); #1; i_data = 32'h0022_0000; i_last = 4'b0100;
        @(negedge i_clk);
        chk("d1_byte1", 32'(o_data), 32'h22);
        chk("d1_ack1", 32'(o_ack), 32'h4);
        @(posedge i_clk); #1; i_req = 4'b0000; i_last = 4'b0000;
        @(negedge i_clk);
        chk("d1_release_busy", 32'(o_busy), 32'h0);

        // Everyone requests single-byte messages: order 3,0,1,2,3 with idle gaps
        @(posedge i_clk); #1; i_req = 4'b1111; i_last = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
`ifdef UART_ARB_HDR_EN
            @(negedge i_clk); chk("rr_hdr", 32'(o_data), 32'(HDR | 8'((3 + i) % NB)));
            @(posedge i_clk); #1;
`endif
            @(negedge i_clk); chk("rr_order", 32'(o_gnt), 32'(1 << ((3 + i) % NB)));
            @(posedge i_clk); #1;
            if (i == 4) i_req = 4'b0000;
            @(negedge i_clk); chk("rr_gap", 32'(o_busy), 32'h0);
        end

        // Owner 1 streams a long message: forced release after MAX_BURST, then 2
        @(posedge i_clk); #1;
        i_req = 4'b0110; i_data = 32'h002A_1B00; i_last = 4'b0100;
        n1 = 0; got2 = 1'b0;
        for (int c = 0; c < 40 && !got2; c++) begin
            @(negedge i_clk);
            if (o_gnt == 4'b0010 && o_ack[1]) n1++;
            if (o_gnt == 4'b0100) got2 = 1'b1;
            @(posedge i_clk); #1;
        end
        chk("burst_bytes", 32'(n1), 32'd16);
        chk("burst_next_owner", 32'(got2), 32'h1);
        i_req = 4'b0000; i_last = 4'b0000;
        repeat (3) @(posedge i_clk);
        #1;

        drive_random(4000);
        @(negedge i_clk);
        chk("burst_release_seen", 32'(burst_hits > 0), 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
